ft_tx_framer: RTL and testbench

FT_TX_FRAMER -- requirements
Module: ft_tx_framer

---
 rtl/ft_tx_framer_pkg.sv | 17 +
 rtl/ft_tx_framer_if.sv | 28 ++
 rtl/ft_tx_framer.sv | 148 ++++++++++++++
 tb/tb_ft_tx_framer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ft_tx_framer_pkg.sv
// Shared types and constants for the FT2232H transmit framer.
package ft_tx_framer_pkg;

    localparam int FT_BYTE_W = 8;

    localparam logic [FT_BYTE_W-1:0] DEF_START_BYTE = 8'hA5;
    localparam logic [FT_BYTE_W-1:0] DEF_STOP_BYTE  = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEQ,
        ST_DATA,
        ST_STOP
    } state_e;

endpackage

// File: rtl/ft_tx_framer_if.sv
// Sample stream plus FT2232H FIFO pins; signal suffixes are from the framer's point of view.
interface ft_tx_framer_if
    import ft_tx_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 12
);

    logic [DATA_WIDTH-1:0] s_data_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [FT_BYTE_W-1:0]  ft_data_o;
    logic                  ft_wr_n_o;
    logic                  ft_txe_n_i;
    logic                  ft_suspend_n_i;
    logic                  ft_siwua_n_o;

    // master: the framer itself; slave: the sample source and the FT2232H side.
    modport master (
        input  s_data_i, s_valid_i, ft_txe_n_i, ft_suspend_n_i,
        output s_ready_o, ft_data_o, ft_wr_n_o, ft_siwua_n_o
    );

    modport slave (
        output s_data_i, s_valid_i, ft_txe_n_i, ft_suspend_n_i,
        input  s_ready_o, ft_data_o, ft_wr_n_o, ft_siwua_n_o
    );

endinterface

// File: rtl/ft_tx_framer.sv
// Frames signed samples as START, seq, sign-extended sample bytes (MSB first), STOP
// and writes them to an FT2232H synchronous FIFO one byte per transfer.
module ft_tx_framer
    import ft_tx_framer_pkg::*;
#(
    parameter int                   DATA_WIDTH     = 12,
    parameter int                   FRAME_SAMPLES  = 1024,
    parameter logic [FT_BYTE_W-1:0] START_BYTE     = DEF_START_BYTE,
    parameter logic [FT_BYTE_W-1:0] STOP_BYTE      = DEF_STOP_BYTE,
    parameter bit                   SEND_IMMEDIATE = 1'b1
) (
    input  logic   clk_i,
    input  logic   rst_n,
    input  logic   enable_i,
    output logic   busy_o,
    output state_e dbg_state_o,
    ft_tx_framer_if.master bus
);

    localparam int NBYTES = (DATA_WIDTH + 7) / 8;
    localparam int SW     = NBYTES * FT_BYTE_W;
    localparam int SCW    = $clog2(FRAME_SAMPLES + 1);
    localparam int BCW    = $clog2(NBYTES + 1);

    state_e               state_q, state_d;
    logic [FT_BYTE_W-1:0] data_q, data_d;
    logic                 pend_q, pend_d;
    logic                 wr_n_q, wr_n_d;
    logic                 last_q, last_d;
    logic                 siwua_n_q, siwua_n_d;
    logic [FT_BYTE_W-1:0] seq_q, seq_d;
    logic [SCW-1:0]       samp_q, samp_d;
    logic [BCW-1:0]       bcnt_q, bcnt_d;
    logic [SW-1:0]        shreg_q, shreg_d;

    logic          xfer;
    logic          slot;
    logic          s_ready;
    logic          accept;
    logic [SW-1:0] ext;

    // Samples use valid/ready: one is taken on every edge where s_valid_i and s_ready_o are high.
    // pend_q marks a byte in data_q not yet transferred; suspend only masks wr_n.
    assign xfer    = !wr_n_q && !bus.ft_txe_n_i;
    assign slot    = bus.ft_suspend_n_i && (!pend_q || xfer);
    assign s_ready = (state_q == ST_DATA) && (samp_q != SCW'(FRAME_SAMPLES))
                     && ((bcnt_q == '0) || ((bcnt_q == BCW'(1)) && slot));
    assign accept  = s_ready && bus.s_valid_i;
    assign ext     = SW'(signed'(bus.s_data_i));

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        pend_d    = pend_q;
        last_d    = last_q;
        seq_d     = seq_q;
        samp_d    = samp_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        if (xfer) begin
            pend_d = 1'b0;
            last_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_START;
            end
            ST_START: begin
                if (slot) begin
                    data_d  = START_BYTE;
                    pend_d  = 1'b1;
                    state_d = ST_SEQ;
                end
            end
            ST_SEQ: begin
                if (slot) begin
                    data_d  = seq_q;
                    pend_d  = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (slot && (bcnt_q != '0)) begin
                    data_d  = shreg_q[SW-1 -: FT_BYTE_W];
                    pend_d  = 1'b1;
                    shreg_d = shreg_q << FT_BYTE_W;
                    bcnt_d  = bcnt_q - BCW'(1);
                    if ((bcnt_q == BCW'(1)) && (samp_q == SCW'(FRAME_SAMPLES))) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (slot) begin
                    data_d  = STOP_BYTE;
                    pend_d  = 1'b1;
                    last_d  = 1'b1;
                    seq_d   = seq_q + 8'd1;
                    samp_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A sample taken alongside its predecessor's last byte reloads the shifter.
        if (accept) begin
            shreg_d = ext;
            bcnt_d  = BCW'(NBYTES);
            samp_d  = samp_q + SCW'(1);
        end
        wr_n_d    = !(pend_d && bus.ft_suspend_n_i);
        siwua_n_d = !(SEND_IMMEDIATE && xfer && last_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            pend_q    <= 1'b0;
            wr_n_q    <= 1'b1;
            last_q    <= 1'b0;
            siwua_n_q <= 1'b1;
            seq_q     <= '0;
            samp_q    <= '0;
            bcnt_q    <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            pend_q    <= pend_d;
            wr_n_q    <= wr_n_d;
            last_q    <= last_d;
            siwua_n_q <= siwua_n_d;
            seq_q     <= seq_d;
            samp_q    <= samp_d;
            bcnt_q    <= bcnt_d;
            shreg_q   <= shreg_d;
        end
    end

    assign bus.s_ready_o    = s_ready;
    assign bus.ft_data_o    = data_q;
    assign bus.ft_wr_n_o    = wr_n_q;
    assign bus.ft_siwua_n_o = siwua_n_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_ft_tx_framer.sv
// Scoreboard bench for ft_tx_framer: 12-bit samples, 4 samples per frame.
module tb_ft_tx_framer;
    import ft_tx_framer_pkg::*;

    localparam int DW = 12;
    localparam int FS = 4;

    logic   clk;
    logic   rst_n;
    logic   enable;
    logic   busy;
    state_e dbg_state;

    ft_tx_framer_if #(.DATA_WIDTH(DW)) bus();

    ft_tx_framer #(.DATA_WIDTH(DW), .FRAME_SAMPLES(FS)) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .busy_o      (busy),
        .dbg_state_o (dbg_state),
        .bus         (bus.master)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [8:0]    exp_q[$];   // bit 8 flags the last byte of a frame
    logic [DW-1:0] src_q[$];
    logic [7:0]    tb_seq   = 8'h00;
    int            gap_cfg  = 0;
    int            gap_left = 0;
    bit            acc;
    bit            siwua_arm = 1'b0;
    bit            hold_v    = 1'b0;
    logic [7:0]    hold_b;
    logic [8:0]    mon_e;
    logic [DW-1:0] smp [FS];
    logic [7:0]    spec_bytes [11] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h07, 8'hFF,
                                       8'hF8, 8'h00, 8'hFF, 8'hFF, 8'h5A};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: one clock, then present the next queued sample (with optional gap)
    task automatic tick();
        @(negedge clk);
        acc = bus.s_valid_i && bus.s_ready_o;
        @(posedge clk);
        #1;
        if (acc) begin
            bus.s_valid_i = 1'b0;
            gap_left      = gap_cfg;
        end
        if (!bus.s_valid_i) begin
            if (gap_left > 0) gap_left--;
            else if (src_q.size() > 0) begin
                bus.s_data_i  = src_q.pop_front();
                bus.s_valid_i = 1'b1;
            end
        end
    endtask

    task automatic rand_samples();
        for (int i = 0; i < FS; i++) smp[i] = DW'($urandom_range(0, 4095));
    endtask

    // mode: 0 plain, 1 txe stall on byte 23, 2 suspend in DATA, 3 reset in DATA
    task automatic run_frame(input int mode, input int gap, input bit lit);
        int         budget;
        int         gap_hi;
        bit         trig;
        bit         aborted;
        logic [15:0] ext;
        gap_cfg = gap;
        if (lit) begin
            for (int i = 0; i < 11; i++) exp_q.push_back({(i == 10), spec_bytes[i]});
        end else begin
            exp_q.push_back({1'b0, 8'hA5});
            exp_q.push_back({1'b0, tb_seq});
            for (int i = 0; i < FS; i++) begin
                ext = {{4{smp[i][DW-1]}}, smp[i]};
                exp_q.push_back({1'b0, ext[15:8]});
                exp_q.push_back({1'b0, ext[7:0]});
            end
            exp_q.push_back({1'b1, 8'h5A});
        end
        tb_seq = tb_seq + 8'd1;
        for (int i = 0; i < FS; i++) src_q.push_back(smp[i]);

        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("start_wr_n_idle_edge", bus.ft_wr_n_o, 1);
        chk("start_busy", busy, 1);

        budget  = 200;
        gap_hi  = 0;
        trig    = 1'b0;
        aborted = 1'b0;
        for (int it = 0; exp_q.size() > 0 && budget > 0 && !aborted; it++) begin
            tick();
            budget--;
            if (it == 0) begin
                chk("start_byte", bus.ft_data_o, 8'hA5);
                chk("start_wr_n", bus.ft_wr_n_o, 0);
            end
            if (dbg_state == ST_DATA && bus.ft_wr_n_o) gap_hi++;
            if (mode == 1 && !trig && !bus.ft_wr_n_o && bus.ft_data_o == 8'h23) begin
                trig = 1'b1;
                bus.ft_txe_n_i = 1'b1;
                repeat (3) begin
                    tick();
                    chk("stall_data", bus.ft_data_o, 8'h23);
                    chk("stall_wr_n", bus.ft_wr_n_o, 0);
                end
                bus.ft_txe_n_i = 1'b0;
            end
            if (mode == 2 && !trig && dbg_state == ST_DATA && !bus.ft_wr_n_o) begin
                trig = 1'b1;
                bus.ft_suspend_n_i = 1'b0;
                repeat (5) begin
                    tick();
                    chk("suspend_wr_n", bus.ft_wr_n_o, 1);
                end
                bus.ft_suspend_n_i = 1'b1;
                tick();
                chk("resume_wr_n", bus.ft_wr_n_o, 0);
            end
            if (mode == 3 && dbg_state == ST_DATA) begin
                aborted = 1'b1;
                src_q.delete();
                bus.s_valid_i = 1'b0;
                gap_left = 0;
                rst_n = 1'b0;
                tick();
                chk("rst_wr_n", bus.ft_wr_n_o, 1);
                chk("rst_busy", busy, 0);
                chk("rst_siwua_n", bus.ft_siwua_n_o, 1);
                chk("rst_s_ready", bus.s_ready_o, 0);
                chk("rst_data", bus.ft_data_o, 8'h00);
                rst_n = 1'b1;
                exp_q.delete();
                tb_seq = 8'h00;
            end
        end
        if (budget == 0) begin
            chk("frame_timeout_left", exp_q.size(), 0);
            exp_q.delete();
            src_q.delete();
        end
        if (gap > 0) chk("gap_wr_n_high_seen", (gap_hi >= 3), 1);
        tick();
        tick();
        chk("idle_hold_busy", busy, 0);
        chk("idle_hold_state", dbg_state, ST_IDLE);
    endtask

    // scoreboard / monitor: a byte moves on the edge after a negedge showing wr_n=0, txe_n=0
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            siwua_arm = 1'b0;
            hold_v    = 1'b0;
        end else begin
            chk("siwua_n", bus.ft_siwua_n_o, siwua_arm ? 0 : 1);
            siwua_arm = 1'b0;
            if (hold_v && !bus.ft_wr_n_o) chk("hold_data", bus.ft_data_o, hold_b);
            hold_v = 1'b0;
            if (!bus.ft_wr_n_o && !bus.ft_txe_n_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ft_byte", bus.ft_data_o, mon_e[7:0]);
                    if (mon_e[8]) siwua_arm = 1'b1;
                end
            end else if (!bus.ft_wr_n_o) begin
                hold_v = 1'b1;
                hold_b = bus.ft_data_o;
            end
        end
    end

    initial begin
        rst_n              = 1'b0;
        enable             = 1'b0;
        bus.s_valid_i      = 1'b0;
        bus.s_data_i       = '0;
        bus.ft_txe_n_i     = 1'b0;
        bus.ft_suspend_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_n", bus.ft_wr_n_o, 1);
        chk("reset_siwua_n", bus.ft_siwua_n_o, 1);
        chk("reset_s_ready", bus.s_ready_o, 0);
        chk("reset_busy", busy, 0);
        chk("reset_data", bus.ft_data_o, 8'h00);
        rst_n = 1'b1;

        smp = '{12'h123, 12'h7FF, 12'h800, 12'hFFF};
        run_frame(0, 0, 1'b1);
        run_frame(1, 0, 1'b0);
        rand_samples();
        run_frame(2, 0, 1'b0);
        rand_samples();
        run_frame(0, 4, 1'b0);
        rand_samples();
        run_frame(3, 0, 1'b0);
        for (int f = 0; f < 257; f++) begin
            rand_samples();
            run_frame(0, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
